cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between result producers: ALU reservation stations 0..2 (req index 0..2) and the load/store buffer (req index 3).
- Grants at most one requester per cycle, round-robin, then drives a registered CDB broadcast.
- The CDB broadcast is consumed by the issue control, the reservation stations, the load/store buffer and the ROB.
- Supports a broadcast hold (ROB write-port back-pressure) and a flush (branch mispredict recovery).

Parameters:
- NUM_REQ, 4, number of CDB requesters; index NUM_REQ-1 is the load/store buffer.
- DATA_WIDTH, 16, result width.
- TAG_WIDTH, 3, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester result-ready request.
- req_tag  in  NUM_REQ*TAG_WIDTH  ROB tag of each requester; requester i occupies slice [i*TAG_WIDTH +: TAG_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  result of each requester; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- cdb_hold  in  1  when high, no grant is issued this cycle.
- flush  in  1  mispredict squash; kills the pending broadcast and resets the arbitration pointer.
- grant  out  NUM_REQ  one-hot or zero, combinational; requester i frees its entry at the posedge where grant[i]=1.
- CDB_out  out  CDB struct (valid, tag, data)  registered broadcast.
- rr_ptr  out  $clog2(NUM_REQ)  current highest-priority index, for debug and verification.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - CDB_out.valid=0, CDB_out.tag=0, CDB_out.data=0, rr_ptr=0.
  - grant forced to 0 while reset_n=0.
- Grant (combinational):
  - If flush=1, cdb_hold=1 or req==0, then grant=0.
  - Otherwise grant the first set req[i], searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - grant is never multi-hot.
- Handshake:
  - A requester holds req, tag and data stable until the cycle its grant is seen.
  - req may be high again in the following cycle with a new result; the arbiter treats it as a new request.
- Broadcast latency is 1 cycle. At the posedge after grant[i]=1:
  - CDB_out.valid=1, tag=req_tag[i], data=req_data[i].
  - If no grant occurred, CDB_out.valid=0; tag and data hold their last values.
- Pointer update at posedge:
  - On grant to i: rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant: unchanged.
  - On flush=1: rr_ptr <= 0 and CDB_out.valid <= 0. Flush has priority over every other event in the same cycle.
- Fairness: a request held continuously is granted within NUM_REQ non-hold, non-flush cycles.
- Boundaries:
  - All requests high: grants rotate 0,1,2,3,0,...
  - Single requester: granted every cycle regardless of rr_ptr.
  - A grant and a cdb_hold in the same cycle cannot occur, because hold suppresses the grant.
  - Requests arriving during hold are kept by their requesters and arbitrated normally once hold drops.
  - Reset asserted mid-broadcast: CDB_out.valid drops immediately (asynchronous); no partial broadcast.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- No buffering of results inside the arbiter; results stay in the requesters until granted.

Decomposition:
- lc3b_types: reuse the existing CDB struct; add localparams CDB_REQ_ALU0..CDB_REQ_ALU2 and CDB_REQ_LDSTR (index constants).
- Sub-module rr_priority_encoder (NUM_REQ param):
  - inputs: req vector and rr_ptr.
  - outputs: one-hot grant and an any-grant flag.
  - purely combinational.
- cdb_arbiter holds the enable gating, rr_ptr and the CDB output register.

Test Plan:
- Reset then idle: reset_n=0 then 1, req=0 -> CDB_out.valid=0, rr_ptr=0, grant=0 for 5 cycles.
- Single request: req=4'b0100, tag 3'd5, data 16'h1234 -> grant=4'b0100 that cycle; next cycle CDB_out={1,5,16'h1234}; rr_ptr=3.
- Round-robin: req=4'b1111 held 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000; CDB_out tags match each requester's tag one cycle later.
- Hold: req=4'b0011 with cdb_hold=1 for 3 cycles -> grant=0 and CDB_out.valid=0 throughout; hold drops -> grant=0001, then 0010.
- Flush: grant to index 2 (rr_ptr becomes 3), flush=1 next cycle with req=4'b1000 -> grant=0, CDB_out.valid=0, rr_ptr=0; following cycle grant=1000.
- Async reset mid-operation: CDB_out.valid=1, assert reset_n=0 between edges -> CDB_out.valid=0 before the next posedge; grant=0 while in reset.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the CDB broadcast record and the CDB requester indices.
package lc3b_types;

    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_TAG_W   = 3;
    localparam int CDB_DATA_W  = 16;

    localparam int CDB_REQ_ALU0  = 0;
    localparam int CDB_REQ_ALU1  = 1;
    localparam int CDB_REQ_ALU2  = 2;
    localparam int CDB_REQ_LDSTR = 3;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first set request at or after i_ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_priority_encoder #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_any
);

    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among result producers, registered broadcast.
// Grant is combinational, broadcast 1 cycle later; cdb_hold/flush suppress the grant, requesters keep their results.
module cdb_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_REQ    = CDB_NUM_REQ,
    parameter int DATA_WIDTH = CDB_DATA_W,
    parameter int TAG_WIDTH  = CDB_TAG_W,
    parameter int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          cdb_hold,
    input  logic                          flush,
    output logic [NUM_REQ-1:0]            grant,
    output cdb_t                          CDB_out,
    output logic [PW-1:0]                 rr_ptr
);

    logic [PW-1:0]         r_rr_ptr;
    cdb_t                  r_cdb;
    logic [NUM_REQ-1:0]    w_enc_gnt;
    logic                  w_enc_any;
    logic                  w_en;
    logic                  w_any_grant;
    logic [PW-1:0]         w_gnt_idx;
    logic [TAG_WIDTH-1:0]  w_sel_tag;
    logic [DATA_WIDTH-1:0] w_sel_data;

    rr_priority_encoder #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_enc (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_enc_gnt),
        .o_any (w_enc_any)
    );

    // Reset is folded in so no grant can free a requester entry while in reset.
    assign w_en        = reset_n & ~flush & ~cdb_hold;
    assign grant       = w_enc_gnt & {NUM_REQ{w_en}};
    assign w_any_grant = w_enc_any & w_en;

    always_comb begin
        w_gnt_idx  = '0;
        w_sel_tag  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_enc_gnt[i]) begin
                w_gnt_idx  = PW'(i);
                w_sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_cdb    <= '0;
        end else if (flush) begin
            r_rr_ptr    <= '0;
            r_cdb.valid <= 1'b0;
        end else if (w_any_grant) begin
            r_rr_ptr    <= (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
            r_cdb.valid <= 1'b1;
            r_cdb.tag   <= w_sel_tag;
            r_cdb.data  <= w_sel_data;
        end else begin
            r_cdb.valid <= 1'b0;
        end
    end

    assign CDB_out = r_cdb;
    assign rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single, round-robin, hold, flush, wrap and async reset.
module tb_cdb_arbiter;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [11:0] req_tag;
    logic [63:0] req_data;
    logic        cdb_hold;
    logic        flush;
    logic [3:0]  grant;
    cdb_t        CDB_out;
    logic [1:0]  rr_ptr;

    int total = 0;
    int bad   = 0;

    logic [2:0]  tags  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [15:0] datas [4] = '{16'hA000, 16'hA111, 16'hA222, 16'hA333};

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_tag  (req_tag),
        .req_data (req_data),
        .cdb_hold (cdb_hold),
        .flush    (flush),
        .grant    (grant),
        .CDB_out  (CDB_out),
        .rr_ptr   (rr_ptr)
    );

    task automatic load_payloads();
        for (int i = 0; i < 4; i++) begin
            req_tag[i*3 +: 3]    = tags[i];
            req_data[i*16 +: 16] = datas[i];
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b1111; cdb_hold = 1'b0; flush = 1'b0;
        load_payloads();
        next_edge();
        #2;
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++;
        if (CDB_out.valid !== 1'b0 || CDB_out.tag !== 3'd0 || CDB_out.data !== 16'h0) begin
            bad++; $display("FAIL reset_cdb: got %b/%0d/%h want 0/0/0000", CDB_out.valid, CDB_out.tag, CDB_out.data);
        end
        req = 4'b0000;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_edge();
            total++;
            if (CDB_out.valid !== 1'b0 || rr_ptr !== 2'd0 || grant !== 4'b0000) begin
                bad++; $display("FAIL idle_%0d: valid=%b ptr=%0d grant=%b want 0/0/0000", c, CDB_out.valid, rr_ptr, grant);
            end
        end
    endtask

    task automatic test_single();
        tags[2] = 3'd5; datas[2] = 16'h1234;
        load_payloads();
        req = 4'b0100;
        #3;
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", grant); end
        next_edge();
        req = 4'b0000;
        total++;
        if (CDB_out !== '{1'b1, 3'd5, 16'h1234} || rr_ptr !== 2'd3) begin
            bad++; $display("FAIL single_cdb: got %b/%0d/%h ptr=%0d want 1/5/1234 ptr=3", CDB_out.valid, CDB_out.tag, CDB_out.data, rr_ptr);
        end
        next_edge();
        total++;
        if (CDB_out !== '{1'b0, 3'd5, 16'h1234} || rr_ptr !== 2'd3) begin
            bad++; $display("FAIL single_idle_hold: got %b/%0d/%h ptr=%0d want 0/5/1234 ptr=3", CDB_out.valid, CDB_out.tag, CDB_out.data, rr_ptr);
        end
        tags[2] = 3'd3; datas[2] = 16'hA222;
        load_payloads();
    endtask

    task automatic test_round_robin();
        // Flush with no requests to bring the pointer back to 0.
        flush = 1'b1;
        next_edge();
        flush = 1'b0;
        total++;
        if (rr_ptr !== 2'd0) begin bad++; $display("FAIL rr_preflush_ptr: got %0d want 0", rr_ptr); end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            #3;
            total++;
            if (grant !== exp_g) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, grant, exp_g); end
            next_edge();
            total++;
            if (CDB_out.valid !== 1'b1 || CDB_out.tag !== tags[k%4] || CDB_out.data !== datas[k%4] || rr_ptr !== 2'((k+1)%4)) begin
                bad++; $display("FAIL rr_cdb_%0d: got %b/%0d/%h ptr=%0d want 1/%0d/%h ptr=%0d", k, CDB_out.valid, CDB_out.tag, CDB_out.data, rr_ptr, tags[k%4], datas[k%4], (k+1)%4);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_hold();
        req = 4'b0011; cdb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            total++;
            if (grant !== 4'b0000) begin bad++; $display("FAIL hold_grant_%0d: got %b want 0000", c, grant); end
            next_edge();
            total++;
            if (CDB_out.valid !== 1'b0 || rr_ptr !== 2'd0) begin
                bad++; $display("FAIL hold_cdb_%0d: valid=%b ptr=%0d want 0/0", c, CDB_out.valid, rr_ptr);
            end
        end
        cdb_hold = 1'b0;
        #3;
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL hold_release_grant0: got %b want 0001", grant); end
        next_edge();
        total++;
        if (CDB_out.valid !== 1'b1 || CDB_out.tag !== tags[0]) begin
            bad++; $display("FAIL hold_release_cdb0: got %b/%0d want 1/%0d", CDB_out.valid, CDB_out.tag, tags[0]);
        end
        #3;
        total++;
        if (grant !== 4'b0010) begin bad++; $display("FAIL hold_release_grant1: got %b want 0010", grant); end
        next_edge();
        req = 4'b0000;
        total++;
        if (CDB_out.tag !== tags[1] || rr_ptr !== 2'd2) begin
            bad++; $display("FAIL hold_release_cdb1: tag=%0d ptr=%0d want %0d/2", CDB_out.tag, rr_ptr, tags[1]);
        end
    endtask

    task automatic test_flush();
        req = 4'b0100;
        #3;
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL flush_pre_grant: got %b want 0100", grant); end
        next_edge();
        total++;
        if (rr_ptr !== 2'd3 || CDB_out.valid !== 1'b1) begin bad++; $display("FAIL flush_pre_ptr: ptr=%0d valid=%b want 3/1", rr_ptr, CDB_out.valid); end
        req = 4'b1000; flush = 1'b1;
        #3;
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL flush_grant: got %b want 0000", grant); end
        next_edge();
        flush = 1'b0;
        total++;
        if (CDB_out.valid !== 1'b0 || rr_ptr !== 2'd0) begin bad++; $display("FAIL flush_state: valid=%b ptr=%0d want 0/0", CDB_out.valid, rr_ptr); end
        #3;
        total++;
        if (grant !== 4'b1000) begin bad++; $display("FAIL flush_after_grant: got %b want 1000", grant); end
        next_edge();
        req = 4'b0000;
        total++;
        if (CDB_out.valid !== 1'b1 || CDB_out.tag !== tags[3] || CDB_out.data !== datas[3] || rr_ptr !== 2'd0) begin
            bad++; $display("FAIL flush_wrap: got %b/%0d/%h ptr=%0d want 1/%0d/%h ptr=0", CDB_out.valid, CDB_out.tag, CDB_out.data, rr_ptr, tags[3], datas[3]);
        end
    endtask

    task automatic test_single_repeat();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            #3;
            total++;
            if (grant !== 4'b0010) begin bad++; $display("FAIL repeat_grant_%0d: got %b want 0010", c, grant); end
            next_edge();
            total++;
            if (CDB_out.valid !== 1'b1 || CDB_out.tag !== tags[1] || rr_ptr !== 2'd2) begin
                bad++; $display("FAIL repeat_cdb_%0d: valid=%b tag=%0d ptr=%0d want 1/%0d/2", c, CDB_out.valid, CDB_out.tag, rr_ptr, tags[1]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        req = 4'b0001;
        next_edge();
        total++;
        if (CDB_out.valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid: got %b want 1", CDB_out.valid); end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (CDB_out.valid !== 1'b0 || rr_ptr !== 2'd0 || grant !== 4'b0000) begin
            bad++; $display("FAIL areset_immediate: valid=%b ptr=%0d grant=%b want 0/0/0000", CDB_out.valid, rr_ptr, grant);
        end
        next_edge();
        total++;
        if (CDB_out.valid !== 1'b0 || grant !== 4'b0000) begin
            bad++; $display("FAIL areset_held: valid=%b grant=%b want 0/0000", CDB_out.valid, grant);
        end
        reset_n = 1'b1;
        req = 4'b0000;
        next_edge();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_tag = '0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_flush();
        test_single_repeat();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
